// File: rtl/pc_sequencer.sv
// Program-counter sequencer: divide-by-DIV step enable, run/halt FSM and prioritised next-PC select.
// Optional macro PC_STEPCOUNT_EN adds a 32-bit StepCount output counting non-halting steps.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               STEP     = 4,
    parameter int               DIV      = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_plus,
    output logic             Tick,
    output logic [1:0]       State
`ifdef PC_STEPCOUNT_EN
    ,
    output logic [31:0]      StepCount
`endif
);

    localparam int               CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick;

    assign tick = (state_q == S_RUN) && (cnt_q == CNT_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Run) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                // Control inputs only matter on the step cycle, highest priority first.
                if (tick) begin
                    if (Halt)        state_d = S_HALTED;
                    else if (Jump)   pc_d    = JumpTarget;
                    else if (Branch) pc_d    = BranchTarget;
                    else if (!Stall) pc_d    = pc_q + STEP_W;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PC_STEPCOUNT_EN
    logic [31:0] sc_q, sc_d;

    assign sc_d = (tick && !Halt) ? sc_q + 32'd1 : sc_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) sc_q <= '0;
        else       sc_q <= sc_d;
    end

    assign StepCount = sc_q;
`endif

    assign PC_out  = pc_q;
    assign PC_plus = pc_q + STEP_W;
    assign Tick    = tick;
    assign State   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer: a 32-bit DIV=1 instance and an
// 8-bit DIV=3 instance share the controls and are compared against a cycle-count model.
module tb_pc_sequencer;

    localparam int DIV_B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, halt, stall, branch, jump;
    logic [31:0] bt, jt;

    logic [31:0] pc_a, plus_a;
    logic        tick_a;
    logic [1:0]  st_a;
    logic [7:0]  pc_b, plus_b;
    logic        tick_b;
    logic [1:0]  st_b;
`ifdef PC_STEPCOUNT_EN
    logic [31:0] sc_a, sc_b;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: mode 0=idle 1=run 2=halted; rc counts cycles spent in RUN since entry.
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    int          m_rc   [2];
    logic [31:0] m_steps[2];

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4), .DIV(1)) dut_a (
        .Clk(clk), .Reset(rst), .Run(run), .Halt(halt), .Stall(stall),
        .Branch(branch), .BranchTarget(bt), .Jump(jump), .JumpTarget(jt),
        .PC_out(pc_a), .PC_plus(plus_a), .Tick(tick_a), .State(st_a)
`ifdef PC_STEPCOUNT_EN
        , .StepCount(sc_a)
`endif
    );

    pc_sequencer #(.WIDTH(8), .RESET_PC(8'hF0), .STEP(4), .DIV(DIV_B)) dut_b (
        .Clk(clk), .Reset(rst), .Run(run), .Halt(halt), .Stall(stall),
        .Branch(branch), .BranchTarget(bt[7:0]), .Jump(jump), .JumpTarget(jt[7:0]),
        .PC_out(pc_b), .PC_plus(plus_b), .Tick(tick_b), .State(st_b)
`ifdef PC_STEPCOUNT_EN
        , .StepCount(sc_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : DIV_B;
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic bit m_tick(input int i);
        return (m_mode[i] == 1) && ((m_rc[i] % div_of(i)) == div_of(i) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]  = 0;
            m_pc[i]    = (i == 0) ? 32'h0 : 32'hF0;
            m_rc[i]    = 0;
            m_steps[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        bit t;
        t = m_tick(i);
        case (m_mode[i])
            1: begin
                if (t) begin
                    if (halt) m_mode[i] = 2;
                    else begin
                        m_steps[i] = m_steps[i] + 1;
                        if (jump)        m_pc[i] = jt & mask_of(i);
                        else if (branch) m_pc[i] = bt & mask_of(i);
                        else if (!stall) m_pc[i] = (m_pc[i] + 4) & mask_of(i);
                    end
                end
                m_rc[i]++;
            end
            default: begin
                if (run) begin
                    m_mode[i] = 1;
                    m_rc[i]   = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, "_a_pc"},    pc_a,           m_pc[0]);
        check_eq({ph, "_a_state"}, {30'd0, st_a},  m_mode[0]);
        check_eq({ph, "_a_tick"},  {31'd0, tick_a}, {31'd0, m_tick(0)});
        check_eq({ph, "_a_plus"},  plus_a,         (m_pc[0] + 4) & mask_of(0));
        check_eq({ph, "_b_pc"},    {24'd0, pc_b},  m_pc[1]);
        check_eq({ph, "_b_state"}, {30'd0, st_b},  m_mode[1]);
        check_eq({ph, "_b_tick"},  {31'd0, tick_b}, {31'd0, m_tick(1)});
        check_eq({ph, "_b_plus"},  {24'd0, plus_b}, (m_pc[1] + 4) & mask_of(1));
`ifdef PC_STEPCOUNT_EN
        check_eq({ph, "_a_steps"}, sc_a, m_steps[0]);
        check_eq({ph, "_b_steps"}, sc_b, m_steps[1]);
`endif
    endtask

    // Called just after a falling edge; leaves the bench at the next falling edge.
    task automatic cycle(input string ph, input logic r, input logic h, input logic s,
                         input logic b, input logic j, input logic [31:0] btv,
                         input logic [31:0] jtv);
        run = r; halt = h; stall = s; branch = b; jump = j; bt = btv; jt = jtv;
        #1;
        check_outputs(ph);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("areset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 0; halt = 0; stall = 0; branch = 0; jump = 0; bt = '0; jt = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Plain sequential run: 0,4,8,... on A and F0..FC wrapping to 00 on B.
        cycle("start", 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) cycle("seq", 0, 0, 0, 0, 0, 0, 0);
        cycle("jmpbr", 0, 0, 0, 1, 1, 32'h200, 32'h100);
        cycle("post_jb", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle("stall", 0, 0, 1, 0, 0, 0, 0);
        cycle("halt", 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cycle("halted", 0, 1, 0, 0, 0, 0, 0);
        cycle("resume", 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle("resumed", 0, 0, 0, 0, 0, 0, 0);
        async_reset();

        for (int k = 0; k < 1500; k++) begin
            cycle("rand",
                  ($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 6) == 0,
                  ($urandom % 8) == 0, ($urandom % 8) == 0, $urandom, $urandom);
            if ((k % 300) == 299) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
